lsu_align: RTL and testbench

- Load/store unit between the core's execute stage and the data RAM.
- Takes one load or store request at a time and drives the RAM's write-enable, store-size, address and write-data inputs.
- Stores that the RAM cannot do in one access are split into sequential byte writes. Loads are served as one or two word reads, with byte-lane extraction and sign/zero extension.
- Returns a registered response to the core.

---
 rtl/lsu_align_if.sv | 43 ++++
 rtl/lsu_align.sv | 273 +++++++++++++++++++++++++++
 tb/tb_lsu_align.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_align_if.sv
// lsu_align_if
//   Groups the load/store unit's core-side request/response handshake and its
//   data-RAM port into one bundle. Clock and reset are plain module ports.
//
//   slave  : the load/store unit itself. It takes requests and read data, and
//            drives the response and the RAM controls.
//   master : the environment, meaning the core plus the RAM. It drives
//            requests and read data, and observes everything else.
//
//   Request : req_valid, req_ready, req_we, req_size, req_unsigned,
//             req_addr, req_wdata
//   Response: resp_valid, resp_rdata
//   RAM     : mem_we, mem_ctrl, mem_addr, mem_wdata, mem_rdata
interface lsu_align_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        mem_we;
   logic [1:0]  mem_ctrl;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  mem_rdata,
      output req_ready, resp_valid, resp_rdata,
      output mem_we, mem_ctrl, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output mem_rdata,
      input  req_ready, resp_valid, resp_rdata,
      input  mem_we, mem_ctrl, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_align.sv
// lsu_align
//   Load/store unit between the execute stage and the data RAM. It handles one
//   request at a time.
//   - Stores the RAM can do in one access take a single write cycle.
//   - A halfword store at offset 3, or a word store at any nonzero offset, is
//     split into sequential byte writes.
//   - A load takes one or two word reads. The bytes are then extracted and
//     sign- or zero-extended.
//   Every output is a register.
//
// Ports
//   clk    : clock, all logic on the rising edge
//   rst_n  : synchronous active-low reset
//   bus    : lsu_align_if.slave, which carries the request/response handshake
//            and the RAM port
//
// Parameter
//   READ_WORD_INDEX : 1 -> read cycles put the word index (byte_addr >> 2) on
//                     mem_addr. 0 -> they put the word-aligned byte address.
//                     Store cycles always carry the byte address.
module lsu_align #(
   parameter int unsigned READ_WORD_INDEX = 1
) (
   input logic       clk,
   input logic       rst_n,
   lsu_align_if.slave bus
);

   // RAM store-size encodings
   localparam logic [1:0] STORE_B  = 2'b00;
   localparam logic [1:0] STORE_HW = 2'b01;
   localparam logic [1:0] STORE_W  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ST   = 3'd1,
      S_LD0  = 3'd2,
      S_LD1  = 3'd3,
      S_LDC  = 3'd4,
      S_RESP = 3'd5
   } state_t;

   state_t      state_r;
   logic [1:0]  size_r;
   logic        uns_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [1:0]  off_r;
   logic [1:0]  idx_r;       // byte index of the current split write
   logic [1:0]  last_idx_r;  // index of the final split write (k-1)
   logic        span_r;
   logic [31:0] lo_r;

   logic        req_ready_r;
   logic        resp_valid_r;
   logic [31:0] resp_rdata_r;
   logic        mem_we_r;
   logic [1:0]  mem_ctrl_r;
   logic [31:0] mem_addr_r;
   logic [31:0] mem_wdata_r;

   logic        acc_s;
   logic        ld_span_s;
   logic [1:0]  last_idx_s;
   logic [1:0]  store_ctrl_s;
   logic [1:0]  idx_next_s;

   // Formats a byte address for a read cycle.
   function automatic logic [31:0] rd_addr_fmt(input logic [31:0] byte_addr);
      logic [31:0] r;
      if (READ_WORD_INDEX != 0) begin
         r = {2'b00, byte_addr[31:2]};
      end else begin
         r = {byte_addr[31:2], 2'b00};
      end
      return r;
   endfunction

   // Number of bytes a request of the given size covers.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      logic [2:0] r;
      case (size)
         2'b00:   r = 3'd1;
         2'b01:   r = 3'd2;
         default: r = 3'd4;
      endcase
      return r;
   endfunction

   // Selects byte lane i of a word.
   function automatic logic [7:0] lane_sel(input logic [31:0] w, input logic [1:0] i);
      logic [7:0] r;
      case (i)
         2'd0:    r = w[7:0];
         2'd1:    r = w[15:8];
         2'd2:    r = w[23:16];
         2'd3:    r = w[31:24];
         default: r = w[7:0];
      endcase
      return r;
   endfunction

   // Shifts {hi,lo} right by the byte offset, then extends to the access size.
   function automatic logic [31:0] extract(input logic [31:0] lo, input logic [31:0] hi,
                                           input logic [1:0] o, input logic [1:0] size,
                                           input logic uns);
      logic [31:0] v;
      logic [31:0] r;
      v = 32'({hi, lo} >> {o, 3'b000});
      case (size)
         2'b00:   r = uns ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
         2'b01:   r = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
         default: r = v;
      endcase
      return r;
   endfunction

   // Decodes the incoming request: accept, split count, span and store size.
   always_comb begin
      acc_s        = bus.req_valid & req_ready_r;
      ld_span_s    = ({1'b0, bus.req_addr[1:0]} + size_bytes(bus.req_size)) > 3'd4;
      last_idx_s   = 2'd0;
      store_ctrl_s = STORE_W;
      if (bus.req_size == 2'b01 && bus.req_addr[1:0] == 2'b11) begin
         last_idx_s = 2'd1;
      end else if (bus.req_size[1] && bus.req_addr[1:0] != 2'b00) begin
         last_idx_s = 2'd3;
      end else begin
         last_idx_s = 2'd0;
      end
      case (bus.req_size)
         2'b00:   store_ctrl_s = STORE_B;
         2'b01:   store_ctrl_s = STORE_HW;
         default: store_ctrl_s = STORE_W;
      endcase
      idx_next_s = idx_r + 2'd1;
   end

   // Control FSM. It holds the request fields and the registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= S_IDLE;
         size_r       <= 2'b00;
         uns_r        <= 1'b0;
         addr_r       <= 32'd0;
         wdata_r      <= 32'd0;
         off_r        <= 2'b00;
         idx_r        <= 2'd0;
         last_idx_r   <= 2'd0;
         span_r       <= 1'b0;
         lo_r         <= 32'd0;
         req_ready_r  <= 1'b0;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= 32'd0;
         mem_we_r     <= 1'b0;
         mem_ctrl_r   <= STORE_W;
         mem_addr_r   <= 32'd0;
         mem_wdata_r  <= 32'd0;
      end else begin
         case (state_r)
            S_IDLE: begin
               resp_valid_r <= 1'b0;
               mem_we_r     <= 1'b0;
               mem_ctrl_r   <= STORE_W;
               mem_addr_r   <= 32'd0;
               mem_wdata_r  <= 32'd0;
               if (acc_s) begin
                  size_r      <= bus.req_size;
                  uns_r       <= bus.req_unsigned;
                  addr_r      <= bus.req_addr;
                  wdata_r     <= bus.req_wdata;
                  off_r       <= bus.req_addr[1:0];
                  idx_r       <= 2'd0;
                  last_idx_r  <= last_idx_s;
                  span_r      <= ld_span_s;
                  req_ready_r <= 1'b0;
                  if (bus.req_we) begin
                     state_r    <= S_ST;
                     mem_we_r   <= 1'b1;
                     mem_addr_r <= bus.req_addr;
                     if (last_idx_s != 2'd0) begin
                        // The first split byte goes out right away. The
                        // response waits for the last byte.
                        mem_ctrl_r   <= STORE_B;
                        mem_wdata_r  <= {24'd0, bus.req_wdata[7:0]};
                        resp_valid_r <= 1'b0;
                     end else begin
                        mem_ctrl_r   <= store_ctrl_s;
                        mem_wdata_r  <= bus.req_wdata;
                        resp_valid_r <= 1'b1;
                     end
                  end else begin
                     state_r    <= S_LD0;
                     mem_addr_r <= rd_addr_fmt({bus.req_addr[31:2], 2'b00});
                  end
               end else begin
                  req_ready_r <= 1'b1;
               end
            end

            S_ST: begin
               if (idx_r == last_idx_r) begin
                  state_r      <= S_IDLE;
                  req_ready_r  <= 1'b1;
                  resp_valid_r <= 1'b0;
                  mem_we_r     <= 1'b0;
                  mem_ctrl_r   <= STORE_W;
                  mem_addr_r   <= 32'd0;
                  mem_wdata_r  <= 32'd0;
               end else begin
                  idx_r        <= idx_next_s;
                  mem_addr_r   <= addr_r + {30'd0, idx_next_s};
                  mem_wdata_r  <= {24'd0, lane_sel(wdata_r, idx_next_s)};
                  resp_valid_r <= (idx_next_s == last_idx_r);
               end
            end

            S_LD0: begin
               if (span_r) begin
                  state_r    <= S_LD1;
                  mem_addr_r <= rd_addr_fmt({addr_r[31:2], 2'b00} + 32'd4);
               end else begin
                  state_r <= S_LDC;
               end
            end

            S_LD1: begin
               // mem_rdata now holds the first word.
               lo_r    <= bus.mem_rdata;
               state_r <= S_LDC;
            end

            S_LDC: begin
               // mem_rdata holds the last word read. It becomes hi when the
               // load spans two words, and lo otherwise.
               if (span_r) begin
                  resp_rdata_r <= extract(lo_r, bus.mem_rdata, off_r, size_r, uns_r);
               end else begin
                  resp_rdata_r <= extract(bus.mem_rdata, 32'd0, off_r, size_r, uns_r);
               end
               resp_valid_r <= 1'b1;
               mem_addr_r   <= 32'd0;
               state_r      <= S_RESP;
            end

            S_RESP: begin
               resp_valid_r <= 1'b0;
               req_ready_r  <= 1'b1;
               state_r      <= S_IDLE;
            end

            default: begin
               state_r      <= S_IDLE;
               req_ready_r  <= 1'b0;
               resp_valid_r <= 1'b0;
               mem_we_r     <= 1'b0;
               mem_ctrl_r   <= STORE_W;
               mem_addr_r   <= 32'd0;
               mem_wdata_r  <= 32'd0;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready_r;
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_rdata = resp_rdata_r;
   assign bus.mem_we     = mem_we_r;
   assign bus.mem_ctrl   = mem_ctrl_r;
   assign bus.mem_addr   = mem_addr_r;
   assign bus.mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align
//   Directed bench for lsu_align. It runs two instances in lockstep, one with
//   READ_WORD_INDEX=1 and one with READ_WORD_INDEX=0, on the same requests.
//   A small byte RAM model serves both. It is written from the first instance
//   and read by both, each with its own address mapping.
module tb_lsu_align;

   localparam logic [1:0] ST_B  = 2'b00;
   localparam logic [1:0] ST_HW = 2'b01;
   localparam logic [1:0] ST_W  = 2'b10;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [31:0] last_rd;

   lsu_align_if bus ();
   lsu_align_if bus0 ();

   lsu_align #(.READ_WORD_INDEX(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus));
   lsu_align #(.READ_WORD_INDEX(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

   assign bus0.req_valid    = bus.req_valid;
   assign bus0.req_we       = bus.req_we;
   assign bus0.req_size     = bus.req_size;
   assign bus0.req_unsigned = bus.req_unsigned;
   assign bus0.req_addr     = bus.req_addr;
   assign bus0.req_wdata    = bus.req_wdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 64-byte RAM indexed by the low six address bits. Every address the bench
   // uses (0x00..0x17 and 0xFFFFFFFC..0xFFFFFFFF) maps to a distinct byte.
   logic [7:0] ram [0:63];

   function automatic logic [31:0] rd_word(input logic [5:0] a);
      return {ram[a + 6'd3], ram[a + 6'd2], ram[a + 6'd1], ram[a]};
   endfunction

   always @(posedge clk) begin
      if (bus.mem_we === 1'b1) begin
         ram[bus.mem_addr[5:0]] <= bus.mem_wdata[7:0];
         if (bus.mem_ctrl != ST_B) ram[bus.mem_addr[5:0] + 6'd1] <= bus.mem_wdata[15:8];
         if (bus.mem_ctrl == ST_W) begin
            ram[bus.mem_addr[5:0] + 6'd2] <= bus.mem_wdata[23:16];
            ram[bus.mem_addr[5:0] + 6'd3] <= bus.mem_wdata[31:24];
         end
      end else begin
         bus.mem_rdata <= rd_word({bus.mem_addr[3:0], 2'b00});
      end
      if (bus0.mem_we !== 1'b1) bus0.mem_rdata <= rd_word(bus0.mem_addr[5:0]);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge while the DUT is idle. Returns at the negedge of T+1.
   task automatic issue(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
      chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      bus.req_valid    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic store_chk(input string tag, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input int k, input logic [1:0] ctrl);
      logic [31:0] w;
      issue(tag, 1'b1, size, 1'b0, addr, wdata);
      for (int i = 0; i < k; i++) begin
         w = wdata >> (8 * i);
         chk($sformatf("%s_we%0d", tag, i), {31'd0, bus.mem_we}, 32'd1);
         chk($sformatf("%s_ctrl%0d", tag, i), {30'd0, bus.mem_ctrl}, {30'd0, (k == 1) ? ctrl : ST_B});
         chk($sformatf("%s_addr%0d", tag, i), bus.mem_addr, (k == 1) ? addr : addr + 32'(i));
         chk($sformatf("%s_wd%0d", tag, i), bus.mem_wdata, (k == 1) ? wdata : {24'd0, w[7:0]});
         chk($sformatf("%s_rv%0d", tag, i), {31'd0, bus.resp_valid}, {31'd0, (i == k - 1)});
         chk($sformatf("%s_rd%0d", tag, i), bus.resp_rdata, last_rd);
         @(negedge clk);
      end
      chk({tag, "_we_end"}, {31'd0, bus.mem_we}, 32'd0);
      chk({tag, "_addr_end"}, bus.mem_addr, 32'd0);
      chk({tag, "_ready_end"}, {31'd0, bus.req_ready}, 32'd1);
   endtask

   task automatic load_chk(input string tag, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic span, input logic [31:0] exp);
      logic [31:0] a0;
      logic [31:0] a1;
      int n;
      a0 = addr & 32'hFFFF_FFFC;
      a1 = a0 + 32'd4;
      issue(tag, 1'b0, size, uns, addr, 32'd0);
      chk({tag, "_a0_idx"}, bus.mem_addr, a0 >> 2);
      chk({tag, "_a0_byte"}, bus0.mem_addr, a0);
      chk({tag, "_we"}, {31'd0, bus.mem_we}, 32'd0);
      @(negedge clk);
      if (span) begin
         chk({tag, "_a1_idx"}, bus.mem_addr, a1 >> 2);
         chk({tag, "_a1_byte"}, bus0.mem_addr, a1);
      end
      n = 2;
      while (bus.resp_valid !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, 32'(n), span ? 32'd4 : 32'd3);
      chk({tag, "_rd1"}, bus.resp_rdata, exp);
      chk({tag, "_rd0"}, bus0.resp_rdata, exp);
      last_rd = exp;
      @(negedge clk);
      chk({tag, "_rv_off"}, {31'd0, bus.resp_valid}, 32'd0);
      chk({tag, "_ready_end"}, {31'd0, bus.req_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      checks           = 0;
      errors           = 0;
      last_rd          = 32'd0;
      rst_n            = 1'b0;
      bus.req_valid    = 1'b1;
      bus.req_we       = 1'b1;
      bus.req_size     = 2'b10;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h0000_0040;
      bus.req_wdata    = 32'hCAFE_F00D;

      // Reset held for 3 cycles while a request is offered.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("rst_ready%0d", i), {31'd0, bus.req_ready}, 32'd0);
         chk($sformatf("rst_we%0d", i), {31'd0, bus.mem_we}, 32'd0);
         chk($sformatf("rst_rv%0d", i), {31'd0, bus.resp_valid}, 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("rel_we", {31'd0, bus.mem_we}, 32'd0);
      chk("rel_rdata", bus.resp_rdata, 32'd0);
      chk("rel_addr", bus.mem_addr, 32'd0);
      chk("rel_ctrl", {30'd0, bus.mem_ctrl}, {30'd0, ST_W});
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("rel_noacc", {31'd0, bus.mem_we}, 32'd0);

      // Aligned word store and load back.
      store_chk("sw8", 2'b10, 32'h0000_0008, 32'hDEAD_BEEF, 1, ST_W);
      load_chk("lw8", 2'b10, 1'b0, 32'h0000_0008, 1'b0, 32'hDEAD_BEEF);

      // Signed and unsigned sub-word loads over 0x80FF0000.
      store_chk("sw8b", 2'b10, 32'h0000_0008, 32'h80FF_0000, 1, ST_W);
      load_chk("lb_b", 2'b00, 1'b0, 32'h0000_000B, 1'b0, 32'hFFFF_FF80);
      load_chk("lbu_b", 2'b00, 1'b1, 32'h0000_000B, 1'b0, 32'h0000_0080);
      load_chk("lh_a", 2'b01, 1'b0, 32'h0000_000A, 1'b0, 32'hFFFF_80FF);

      // Misaligned word store split into four byte writes, then a spanning load.
      store_chk("sw5", 2'b10, 32'h0000_0005, 32'h1122_3344, 4, ST_W);
      load_chk("lw5", 2'b10, 1'b0, 32'h0000_0005, 1'b1, 32'h1122_3344);

      // Address wrap: A5 at 0xFFFFFFFF and 9C at 0x0 give 0x9CA5.
      store_chk("sb_top", 2'b00, 32'hFFFF_FFFF, 32'h1234_56A5, 1, ST_B);
      store_chk("sb_zero", 2'b00, 32'h0000_0000, 32'h0000_009C, 1, ST_B);
      load_chk("lh_wrap", 2'b01, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_9CA5);
      load_chk("lhu_wrap", 2'b01, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_9CA5);

      // Halfword at offset 3 splits in two. At offset 1 it stays one access.
      store_chk("sh13", 2'b01, 32'h0000_0013, 32'h0000_BEEF, 2, ST_HW);
      store_chk("sh11", 2'b01, 32'h0000_0011, 32'h0000_CAFE, 1, ST_HW);
      load_chk("lhu13", 2'b01, 1'b1, 32'h0000_0013, 1'b1, 32'h0000_BEEF);

      // Reset during the LD1 cycle of a spanning load.
      issue("rst_ld", 1'b0, 2'b10, 1'b0, 32'h0000_0005, 32'd0);
      @(negedge clk);
      chk("rst_ld_a1", bus.mem_addr, 32'h0000_0002);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_ld_we", {31'd0, bus.mem_we}, 32'd0);
      chk("rst_ld_rv", {31'd0, bus.resp_valid}, 32'd0);
      chk("rst_ld_ready0", {31'd0, bus.req_ready}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ld_ready1", {31'd0, bus.req_ready}, 32'd1);
      chk("rst_ld_rv1", {31'd0, bus.resp_valid}, 32'd0);
      chk("rst_ld_rdata", bus.resp_rdata, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rst_ld_quiet%0d", i), {31'd0, bus.resp_valid}, 32'd0);
      end
      last_rd = 32'd0;
      load_chk("lbu5", 2'b00, 1'b1, 32'h0000_0005, 1'b0, 32'h0000_0044);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
